exu_mem_responder: RTL and testbench

- Memory-side responder for the load/store requests that the execute stage generates (read address, write address, write data, write enable).
- Holds a word-organised data memory and services one request at a time over a valid/ready request and response handshake.
- Access latency is configurable; out-of-range accesses return an error flag.
- Sits between the execute stage and the LSU/writeback path. Replaces the zero-latency combinational memory model in simulation and on FPGA.

---
 rtl/exu_mem_responder.sv | 127 ++++++++++++
 tb/tb_exu_mem_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mem_responder.sv
// exu_mem_responder: word-organised data memory behind a valid/ready request
// and response handshake, with a fixed access latency and range checking.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, misaligned
// addresses (addr[1:0] != 0) are reported as errors and nothing is written.
module exu_mem_responder #(
    parameter int                   ISA_WIDTH  = 32,
    parameter int                   DEPTH_LOG2 = 10,
    parameter logic [ISA_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
    parameter int                   LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ISA_WIDTH-1:0]   req_addr,
    input  logic [ISA_WIDTH-1:0]   req_wdata,
    input  logic [ISA_WIDTH/8-1:0] req_wmask,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ISA_WIDTH-1:0]   resp_rdata,
    output logic                   resp_err
);

    localparam int                   LANES      = ISA_WIDTH / 8;
    localparam int                   WORDS      = 1 << DEPTH_LOG2;
    localparam logic [ISA_WIDTH-1:0] WORDS_W    = ISA_WIDTH'(WORDS);
    localparam logic [3:0]           COUNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    logic [3:0]             count;
    logic                   lat_we;
    logic [ISA_WIDTH-1:0]   lat_addr;
    logic [ISA_WIDTH-1:0]   lat_wdata;
    logic [LANES-1:0]       lat_wmask;

    logic [ISA_WIDTH-1:0]   mem [WORDS];

    logic [ISA_WIDTH-1:0]   offset;
    logic                   in_range;
    logic                   access_err;
    logic [DEPTH_LOG2-1:0]  index;
    logic                   do_access;
    logic                   do_write;

    // Address decode of the latched request: unsigned offset from the base,
    // word index, and the error decision used by both the write and the response.
    assign offset    = lat_addr - BASE_ADDR;
    assign in_range  = (lat_addr >= BASE_ADDR) && ((offset >> 2) < WORDS_W);
    assign index     = offset[DEPTH_LOG2+1:2];
`ifdef MEM_ALIGN_CHECK_EN
    assign access_err = !in_range || (lat_addr[1:0] != 2'b00);
`else
    assign access_err = !in_range;
`endif
    assign do_access = (state == WAIT) && (count == 4'd0);
    assign do_write  = do_access && lat_we && !access_err;

    // Memory array: byte-lane masked store on the access edge, never reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (lat_wmask[i]) begin
                    mem[index][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM: accept in IDLE, count down latency in WAIT,
    // hold the registered response in RESP until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wmask <= req_wmask;
                        count     <= COUNT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= access_err;
                        resp_rdata <= (!lat_we && !access_err) ? mem[index] : '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exu_mem_responder.sv
// tb_exu_mem_responder: directed self-checking bench for exu_mem_responder
// with default parameters (LATENCY=2, BASE_ADDR=0x80000000, 1024 words).
module tb_exu_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors;
    int checks;

    exu_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Runs one full transaction from IDLE: request accepted at edge N, lat is
    // the number of edges until resp_valid is seen (-1 on timeout).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, output int lat,
                         output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) lat = -1;
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int          lat;
        logic [31:0] rd;
        logic        er;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp_data: got rdata=%h err=%b expected 0/0", resp_rdata, resp_err);
        end
        rst = 1'b1;

        issue(1'b1, 32'h80000010, 32'h55667788, 4'hF, lat, rd, er);

        // Start a store and pull reset while it is still counting down.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h80000010;
        req_wdata = 32'h99999999;
        req_wmask = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait_held: got ready=%b valid=%b expected 1/0", req_ready, resp_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1/0", req_ready, resp_valid);
        end

        issue(1'b0, 32'h80000010, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h55667788 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_store_dropped: got rdata=%h err=%b expected 55667788/0", rd, er);
        end
    endtask

    task automatic test_store_load();
        int          lat;
        logic [31:0] rd;
        logic        er;
        issue(1'b1, 32'h80000004, 32'hDEADBEEF, 4'hF, lat, rd, er);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL store_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_resp: got rdata=%h err=%b expected 00000000/0", rd, er);
        end
        issue(1'b0, 32'h80000004, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL load_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_data: got rdata=%h err=%b expected deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte_mask();
        int          lat;
        logic [31:0] rd;
        logic        er;
        issue(1'b1, 32'h80000008, 32'h11223344, 4'hF, lat, rd, er);
        issue(1'b1, 32'h80000008, 32'hAABBCCDD, 4'b0101, lat, rd, er);
        issue(1'b0, 32'h80000008, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("[TB] FAIL byte_mask_0101: got %h expected 11bb33dd", rd);
        end
        issue(1'b1, 32'h80000008, 32'hFFFFFFFF, 4'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0 || lat !== 2) begin
            errors++;
            $display("[TB] FAIL zero_mask_resp: got rdata=%h err=%b lat=%0d expected 0/0/2", rd, er, lat);
        end
        issue(1'b0, 32'h80000008, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("[TB] FAIL zero_mask_nochange: got %h expected 11bb33dd", rd);
        end
        issue(1'b1, 32'h80000008, 32'h5566AA00, 4'b1010, lat, rd, er);
        issue(1'b0, 32'h80000008, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h55BBAADD) begin
            errors++;
            $display("[TB] FAIL byte_mask_1010: got %h expected 55bbaadd", rd);
        end
    endtask

    task automatic test_range();
        int          lat;
        logic [31:0] rd;
        logic        er;
        issue(1'b1, 32'h80000000, 32'hCAFEF00D, 4'hF, lat, rd, er);
        issue(1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
            errors++;
            $display("[TB] FAIL range_below: got err=%b rdata=%h lat=%0d expected 1/0/2", er, rd, lat);
        end
        issue(1'b0, 32'h80001000, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL range_above_load: got err=%b rdata=%h expected 1/0", er, rd);
        end
        issue(1'b1, 32'h80001000, 32'h12345678, 4'hF, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL range_above_store: got err=%b rdata=%h expected 1/0", er, rd);
        end
        issue(1'b0, 32'h80000000, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL range_word0_intact: got rdata=%h err=%b expected cafef00d/0", rd, er);
        end
        issue(1'b1, 32'h80000FFC, 32'h0F1E2D3C, 4'hF, lat, rd, er);
        issue(1'b0, 32'h80000FFC, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0F1E2D3C || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL range_last_word: got rdata=%h err=%b expected 0f1e2d3c/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] rd;
        logic        er;
        issue(1'b1, 32'h8000000C, 32'h0BADF00D, 4'hF, lat, rd, er);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8000000C;
        req_wmask = 4'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL stall_latency: got %0d expected 2", lat);
        end

        // Hold the response while a competing store sits on the request port.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h8000000C;
            req_wdata = 32'hFFFFFFFF;
            req_wmask = 4'hF;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADF00D || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_cycle_%0d: got valid=%b rdata=%h err=%b ready=%b expected 1/0badf00d/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
        end
        issue(1'b0, 32'h8000000C, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("[TB] FAIL stall_req_ignored: got %h expected 0badf00d", rd);
        end
    endtask

    task automatic test_align();
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_word;
        logic        exp_err;
        issue(1'b1, 32'h80000004, 32'h01020304, 4'hF, lat, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 32'h01020304;
`else
        exp_err  = 1'b0;
        exp_word = 32'hA5A5A5A5;
`endif
        issue(1'b1, 32'h80000006, 32'hA5A5A5A5, 4'hF, lat, rd, er);
        checks++;
        if (er !== exp_err || rd !== 32'h0 || lat !== 2) begin
            errors++;
            $display("[TB] FAIL align_store_resp: got err=%b rdata=%h lat=%0d expected %b/0/2", er, rd, lat, exp_err);
        end
        issue(1'b0, 32'h80000004, 32'h0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== exp_word || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL align_word: got rdata=%h err=%b expected %h/0", rd, er, exp_word);
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wmask  = 4'h0;
        resp_ready = 1'b0;

        test_reset();
        test_store_load();
        test_byte_mask();
        test_range();
        test_backpressure();
        test_align();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
